// File: rtl/boton_pkg.sv
// Shared types and helpers for the push-button front end (boton_pulse_array).
package boton_pkg;

  // Per-channel press state; REPEAT is only reachable when AUTOREPEAT_EN is defined.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } btn_st_t;

  localparam int N_CH_DEF       = 4;
  localparam int DEB_CYCLES_DEF = 16;
  localparam int REP_DELAY_DEF  = 1000;
  localparam int REP_PERIOD_DEF = 250;

  // Counter width large enough to hold the largest terminal count without wrapping.
  function automatic int cnt_w(input int deb, input int dly, input int per);
    int m;
    m = deb;
    if (dly > m) m = dly;
    if (per > m) m = per;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/boton_chan.sv
// One button channel: 2-flop synchroniser, debouncer, press FSM and (with
// AUTOREPEAT_EN defined) a hold counter generating repeat pulses.
//
// Handshake note: there is no valid/ready pair here; pulse is a single-cycle
// strobe and level is a plain registered level, both valid every cycle.
module boton_chan
  import boton_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int REP_DELAY  = REP_DELAY_DEF,
  parameter int REP_PERIOD = REP_PERIOD_DEF
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    boton_n,
  input  logic    en,
  output logic    pulse,
  output logic    pulse_nxt,
  output logic    level,
  output btn_st_t st
);

  localparam int CW = cnt_w(DEB_CYCLES, REP_DELAY, REP_PERIOD);
  localparam logic [CW-1:0] DEB_TOP = CW'(DEB_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  btn_st_t       st_q, st_d;
  logic          fire;

  // Synchroniser: invert so that 1 means pressed from the first flop on.
  always_comb begin
    s1_d = ~boton_n;
    s2_d = s1_q;
  end

  // Debounce: accept a new level only after DEB_CYCLES consecutive disagreeing samples.
  always_comb begin
    level_d = level_q;
    dcnt_d  = '0;
    if (s2_q != level_q) begin
      if (dcnt_q >= DEB_TOP) begin
        level_d = s2_q;
      end else begin
        dcnt_d = dcnt_q + CW'(1);
      end
    end
  end

`ifdef AUTOREPEAT_EN
  localparam logic [CW-1:0] DLY_TOP = CW'(REP_DELAY - 1);
  localparam logic [CW-1:0] PER_TOP = CW'(REP_PERIOD - 1);

  logic [CW-1:0] hcnt_q, hcnt_d;

  // Press FSM with autorepeat; release (level falling) beats any repeat tick.
  always_comb begin
    st_d   = st_q;
    hcnt_d = hcnt_q;
    fire   = 1'b0;
    case (st_q)
      IDLE: begin
        hcnt_d = '0;
        if (level_d && !level_q) begin
          st_d = HELD;
          fire = 1'b1;
        end
      end
      HELD: begin
        if (!level_d) begin
          st_d   = IDLE;
          hcnt_d = '0;
        end else if (hcnt_q >= DLY_TOP) begin
          st_d   = REPEAT;
          hcnt_d = '0;
          fire   = 1'b1;
        end else begin
          hcnt_d = hcnt_q + CW'(1);
        end
      end
      REPEAT: begin
        if (!level_d) begin
          st_d   = IDLE;
          hcnt_d = '0;
        end else if (hcnt_q >= PER_TOP) begin
          hcnt_d = '0;
          fire   = 1'b1;
        end else begin
          hcnt_d = hcnt_q + CW'(1);
        end
      end
      default: begin
        st_d   = IDLE;
        hcnt_d = '0;
      end
    endcase
  end

  // Hold counter register.
  always_ff @(posedge clk) begin
    if (rst) hcnt_q <= '0;
    else     hcnt_q <= hcnt_d;
  end
`else
  // Press FSM without autorepeat: one pulse per debounced press.
  always_comb begin
    st_d = st_q;
    fire = 1'b0;
    case (st_q)
      IDLE: begin
        if (level_d && !level_q) begin
          st_d = HELD;
          fire = 1'b1;
        end
      end
      HELD: begin
        if (!level_d) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end
`endif

  // Pulse is masked by en in the cycle it would fire; en never touches FSM or level.
  always_comb begin
    pulse_d = fire & en;
  end

  // State registers for sync, debounce, FSM and pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      dcnt_q  <= '0;
      st_q    <= IDLE;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      dcnt_q  <= dcnt_d;
      st_q    <= st_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse     = pulse_q;
  assign pulse_nxt = rst ? 1'b0 : pulse_d;
  assign level     = level_q;
  assign st        = st_q;

endmodule

// File: rtl/boton_pulse_array.sv
// N-channel push-button front end: one boton_chan per button plus a registered
// any_pulse. Define AUTOREPEAT_EN to build in hold-to-autorepeat.
// dbg_st exposes each channel's press state (2 bits per channel, btn_st_t encoding).
module boton_pulse_array
  import boton_pkg::*;
#(
  parameter int N_CH       = N_CH_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int REP_DELAY  = REP_DELAY_DEF,
  parameter int REP_PERIOD = REP_PERIOD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   boton,
  input  logic [N_CH-1:0]   en,
  output logic [N_CH-1:0]   pulse,
  output logic [N_CH-1:0]   level,
  output logic              any_pulse,
  output logic [2*N_CH-1:0] dbg_st
);

  logic [N_CH-1:0] pulse_nxt;
  logic            any_pulse_q, any_pulse_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    btn_st_t chan_st;

    boton_chan #(
      .DEB_CYCLES (DEB_CYCLES),
      .REP_DELAY  (REP_DELAY),
      .REP_PERIOD (REP_PERIOD)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .boton_n   (boton[i]),
      .en        (en[i]),
      .pulse     (pulse[i]),
      .pulse_nxt (pulse_nxt[i]),
      .level     (level[i]),
      .st        (chan_st)
    );

    assign dbg_st[2*i +: 2] = chan_st;
  end

  // any_pulse is registered alongside the channel pulses so both rise in the same cycle.
  always_comb begin
    any_pulse_d = |pulse_nxt;
  end

  // any_pulse register.
  always_ff @(posedge clk) begin
    if (rst) any_pulse_q <= 1'b0;
    else     any_pulse_q <= any_pulse_d;
  end

  assign any_pulse = any_pulse_q;

endmodule

// File: tb/tb_boton_pulse_array.sv
// Bench for boton_pulse_array (DEB_CYCLES=4, REP_DELAY=10, REP_PERIOD=3, N_CH=4).
// Reference model works from the debounce window rule and the elapsed hold time.
module tb_boton_pulse_array;
  import boton_pkg::*;

  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int DLY = 10;
  localparam int PER = 3;
  localparam int W   = 4 * N + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   boton = '1;
  logic [N-1:0]   en = '1;
  logic [N-1:0]   pulse;
  logic [N-1:0]   level;
  logic           any_pulse;
  logic [2*N-1:0] dbg_st;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // model state
  bit           hist[N][$];
  logic [N-1:0] m_level = '0;
  int           age[N];
  logic [W-1:0] exp_q[$];

  boton_pulse_array #(
    .N_CH(N), .DEB_CYCLES(DEB), .REP_DELAY(DLY), .REP_PERIOD(PER)
  ) dut (
    .clk(clk), .rst(rst), .boton(boton), .en(en),
    .pulse(pulse), .level(level), .any_pulse(any_pulse), .dbg_st(dbg_st)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  // Model of one posedge given the inputs now applied; pushes the expected outputs.
  task automatic model_edge();
    logic [N-1:0]   m_pulse;
    logic [2*N-1:0] m_st;
    for (int i = 0; i < N; i++) begin
      bool_step(i, m_pulse[i], m_st[2*i +: 2]);
    end
    exp_q.push_back({m_st, |m_pulse, m_level, m_pulse});
  endtask

  task automatic bool_step(input int i, output logic p, output logic [1:0] s);
    bit all_diff;
    bit rose;
    int n;
    p = 1'b0;
    if (rst) begin
      hist[i].delete();
      for (int k = 0; k < DEB + 2; k++) hist[i].push_back(1'b0);
      m_level[i] = 1'b0;
      age[i] = 0;
      s = IDLE;
      return;
    end
    // level flips when the DEB synchronised samples ahead of this edge all disagree with it
    n = hist[i].size();
    all_diff = 1'b1;
    for (int j = n - 1 - DEB; j <= n - 2; j++)
      if (hist[i][j] == m_level[i]) all_diff = 1'b0;
    rose = 1'b0;
    if (all_diff) begin
      m_level[i] = ~m_level[i];
      rose = m_level[i];
    end
    if (rose) age[i] = 0;
    else if (m_level[i]) age[i]++;
    p = rose;
`ifdef AUTOREPEAT_EN
    if (m_level[i] && !rose && age[i] >= DLY && ((age[i] - DLY) % PER) == 0) p = 1'b1;
    s = !m_level[i] ? IDLE : (age[i] >= DLY ? REPEAT : HELD);
`else
    s = m_level[i] ? HELD : IDLE;
`endif
    p = p & en[i];
    hist[i].push_back(~boton[i]);
    if (hist[i].size() > DEB + 2) void'(hist[i].pop_front());
  endtask

  // One clock: drive inputs away from the edge, model, then compare after the edge.
  task automatic tick(input logic r, input logic [N-1:0] b, input logic [N-1:0] e);
    logic [W-1:0] ex;
    @(negedge clk);
    rst = r; boton = b; en = e;
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    ex = exp_q.pop_front();
    check("pulse", 32'(pulse), 32'(ex[N-1:0]));
    check("level", 32'(level), 32'(ex[2*N-1:N]));
    check("any_pulse", 32'(any_pulse), 32'(ex[2*N]));
    check("state", 32'(dbg_st), 32'(ex[W-1:2*N+1]));
  endtask

  task automatic hold(input int cycles, input logic [N-1:0] b, input logic [N-1:0] e);
    for (int k = 0; k < cycles; k++) tick(1'b0, b, e);
  endtask

  int n_pulse0;

  initial begin
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < DEB + 2; k++) hist[i].push_back(1'b0);
      age[i] = 0;
    end
    // reset
    tick(1'b1, '1, '1);
    tick(1'b1, '1, '1);

    // press ch0 for 40 cycles; exactly one pulse expected without autorepeat
    n_pulse0 = 0;
    for (int k = 0; k < 40; k++) begin
      tick(1'b0, 4'b1110, '1);
      if (k == 4) check("press_latency_level", 32'(level[0]), 32'd0);
      if (k == 5) check("press_latency_pulse", 32'(pulse[0]), 32'd1);
      n_pulse0 += int'(pulse[0]);
    end
`ifndef AUTOREPEAT_EN
    check("single_pulse_count", 32'(n_pulse0), 32'd1);
`endif
    hold(10, '1, '1);

    // bounce ch1 every cycle for 12 cycles
    for (int k = 0; k < 12; k++) tick(1'b0, (k % 2 == 0) ? 4'b1101 : 4'b1111, '1);
    hold(10, '1, '1);

    // hold ch2 for 30 cycles then release
    hold(30, 4'b1011, '1);
    hold(10, '1, '1);

    // en[3]=0 during press, enabled mid-hold
    hold(10, 4'b0111, 4'b0111);
    hold(10, 4'b0111, 4'b1111);
    hold(10, '1, '1);

    // simultaneous press of ch0 and ch1
    hold(10, 4'b1100, '1);
    hold(10, '1, '1);

    // reset while ch0 held with level up
    hold(10, 4'b1110, '1);
    tick(1'b1, 4'b1110, '1);
    hold(15, 4'b1110, '1);
    hold(10, '1, '1);

    // randomised slow-changing buttons, random enables, rare resets
    for (int k = 0; k < 2000; k++) begin
      logic [N-1:0] b;
      logic [N-1:0] e;
      b = boton;
      for (int i = 0; i < N; i++)
        if ($urandom_range(7, 0) == 0) b[i] = ~b[i];
      e = ($urandom_range(3, 0) == 0) ? N'($urandom_range(15, 0)) : '1;
      tick(($urandom_range(499, 0) == 0), b, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
